// File: rtl/trig_link_pkg.sv
// Shared definitions for the main <-> channel trigger link.
// Word encodings, trigger-word field layout and the receiver lock states.
package trig_link_pkg;

    localparam logic [15:0] CH_COMMA   = 16'h00BC;
    localparam logic [15:0] CH_TRIG    = 16'h801C;
    localparam int          TRIG_FLAG  = 15;
    localparam int          TRIG_NUM_W = 15;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } link_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_TRIG = 2'd1,
        W_BAD  = 2'd2
    } word_class_t;

    function automatic word_class_t classify(input logic [15:0] data, input logic kchar);
        word_class_t cls;
        if (kchar && data == CH_COMMA)
            cls = W_IDLE;
        else if (!kchar && data[TRIG_FLAG])
            cls = W_TRIG;
        else
            cls = W_BAD;
        return cls;
    endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst)
            cnt_reg <= '0;
        else if (clr)
            cnt_reg <= '0;
        else if (inc && cnt_reg != {W{1'b1}})
            cnt_reg <= cnt_reg + 1'b1;
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/trig_rx.sv
// Channel-side trigger link receiver: comma lock, trigger strobe with number,
// continuity check and slow-control statistics counters.
module trig_rx
    import trig_link_pkg::*;
#(
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           data_i,
    input  logic                  kchar_i,
    input  logic                  cnt_clr_i,
    output logic                  trig_o,
    output logic [TRIG_NUM_W-1:0] trig_num_o,
    output logic                  seq_err_o,
    output logic                  locked_o,
    output logic [31:0]           trig_cnt_o,
    output logic [15:0]           bad_cnt_o,
    output logic [15:0]           seq_cnt_o
);

    localparam int CW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);

    link_state_t           state_reg, state_next;
    logic [CW-1:0]         comma_run_reg, comma_run_next;
    logic [BW-1:0]         bad_run_reg, bad_run_next;
    logic                  first_reg, first_next;
    logic [TRIG_NUM_W-1:0] expected_reg, expected_next;
    logic                  trig_reg, trig_next;
    logic [TRIG_NUM_W-1:0] trig_num_reg, trig_num_next;
    logic                  seq_err_reg, seq_err_next;
    logic                  locked_reg, locked_next;
    logic [31:0]           trig_cnt_reg;
    logic                  trig_inc, bad_inc, seq_inc;

    word_class_t           word_cls;
    logic [TRIG_NUM_W-1:0] word_num;

    assign word_cls = classify(data_i, kchar_i);
    assign word_num = data_i[TRIG_NUM_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= HUNT;
            comma_run_reg <= '0;
            bad_run_reg   <= '0;
            first_reg     <= 1'b1;
            expected_reg  <= '0;
            trig_reg      <= 1'b0;
            trig_num_reg  <= '0;
            seq_err_reg   <= 1'b0;
            locked_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            comma_run_reg <= comma_run_next;
            bad_run_reg   <= bad_run_next;
            first_reg     <= first_next;
            expected_reg  <= expected_next;
            trig_reg      <= trig_next;
            trig_num_reg  <= trig_num_next;
            seq_err_reg   <= seq_err_next;
            locked_reg    <= locked_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        comma_run_next = comma_run_reg;
        bad_run_next   = bad_run_reg;
        first_next     = first_reg;
        expected_next  = expected_reg;
        trig_next      = 1'b0;
        trig_num_next  = trig_num_reg;
        seq_err_next   = 1'b0;
        locked_next    = locked_reg;
        trig_inc       = 1'b0;
        bad_inc        = 1'b0;
        seq_inc        = 1'b0;

        case (state_reg)
            HUNT: begin
                if (word_cls == W_IDLE) begin
                    if (comma_run_reg == CW'(LOCK_CNT - 1)) begin
                        state_next     = LOCKED;
                        locked_next    = 1'b1;
                        comma_run_next = '0;
                        bad_run_next   = '0;
                        first_next     = 1'b1;
                    end else begin
                        comma_run_next = comma_run_reg + 1'b1;
                    end
                end else begin
                    comma_run_next = '0;
                end
            end
            LOCKED: begin
                case (word_cls)
                    W_IDLE: bad_run_next = '0;
                    W_TRIG: begin
                        bad_run_next  = '0;
                        trig_next     = 1'b1;
                        trig_num_next = word_num;
                        trig_inc      = 1'b1;
                        // The first trigger after lock re-seeds the expected number.
                        if (first_reg)
                            first_next = 1'b0;
                        else if (word_num != expected_reg) begin
                            seq_err_next = 1'b1;
                            seq_inc      = 1'b1;
                        end
                        expected_next = word_num + 1'b1;
                    end
                    default: begin
                        bad_inc = 1'b1;
                        if (bad_run_reg == BW'(UNLOCK_CNT - 1)) begin
                            state_next     = HUNT;
                            locked_next    = 1'b0;
                            comma_run_next = '0;
                            bad_run_next   = '0;
                        end else begin
                            bad_run_next = bad_run_reg + 1'b1;
                        end
                    end
                endcase
            end
            default: state_next = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            trig_cnt_reg <= '0;
        else if (cnt_clr_i)
            trig_cnt_reg <= '0;
        else if (trig_inc)
            trig_cnt_reg <= trig_cnt_reg + 32'd1;
    end

    sat_cnt #(.W(16)) u_bad_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr_i),
        .inc (bad_inc),
        .cnt (bad_cnt_o)
    );

    sat_cnt #(.W(16)) u_seq_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr_i),
        .inc (seq_inc),
        .cnt (seq_cnt_o)
    );

    assign trig_o     = trig_reg;
    assign trig_num_o = trig_num_reg;
    assign seq_err_o  = seq_err_reg;
    assign locked_o   = locked_reg;
    assign trig_cnt_o = trig_cnt_reg;

endmodule

// File: tb/tb_trig_rx.sv
// Directed bench for trig_rx; a second instance with a large unlock threshold
// stays locked through a long BAD stream so bad_cnt saturation can be reached.
module tb_trig_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic        kchar;
    logic        cnt_clr;

    logic        trig, seq_err, locked;
    logic [14:0] trig_num;
    logic [31:0] trig_cnt;
    logic [15:0] bad_cnt, seq_cnt;

    logic        s_trig, s_seq_err, s_locked;
    logic [14:0] s_trig_num;
    logic [31:0] s_trig_cnt;
    logic [15:0] s_bad_cnt, s_seq_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trig_rx u_dut (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data),
        .kchar_i    (kchar),
        .cnt_clr_i  (cnt_clr),
        .trig_o     (trig),
        .trig_num_o (trig_num),
        .seq_err_o  (seq_err),
        .locked_o   (locked),
        .trig_cnt_o (trig_cnt),
        .bad_cnt_o  (bad_cnt),
        .seq_cnt_o  (seq_cnt)
    );

    trig_rx #(.LOCK_CNT(16), .UNLOCK_CNT(100000)) u_sat (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data),
        .kchar_i    (kchar),
        .cnt_clr_i  (cnt_clr),
        .trig_o     (s_trig),
        .trig_num_o (s_trig_num),
        .seq_err_o  (s_seq_err),
        .locked_o   (s_locked),
        .trig_cnt_o (s_trig_cnt),
        .bad_cnt_o  (s_bad_cnt),
        .seq_cnt_o  (s_seq_cnt)
    );

    // One word per clock: drive at negedge, sample 1 ns after the capturing edge.
    task automatic send(input logic [15:0] d, input logic k);
        @(negedge clk);
        data  = d;
        kchar = k;
        @(posedge clk);
        #1;
    endtask

    task automatic send_idle();
        send(16'h00BC, 1'b1);
    endtask

    task automatic relock();
        rst = 1'b1;
        send_idle();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) send_idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cnt_clr = 1'b0;
        send(16'h8001, 1'b0);
        send_idle();
        rst = 1'b0;
        $display("reset: trig=%0b num=%h seq=%0b lock=%0b tc=%0d bc=%0d sc=%0d",
                 trig, trig_num, seq_err, locked, trig_cnt, bad_cnt, seq_cnt);
        checks++;
        if ({trig, trig_num, seq_err, locked} !== 18'd0) begin
            errors++;
            $display("FAIL reset_outputs got trig=%0b num=%h seq=%0b lock=%0b want all 0",
                     trig, trig_num, seq_err, locked);
        end
        checks++;
        if (trig_cnt !== 32'd0 || bad_cnt !== 16'd0 || seq_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters got tc=%0d bc=%0d sc=%0d want 0 0 0",
                     trig_cnt, bad_cnt, seq_cnt);
        end
    endtask

    task automatic test_lock();
        logic early;
        early = 1'b0;
        for (int i = 0; i < 15; i++) begin
            send_idle();
            early |= locked;
        end
        $display("lock: after 15 commas locked=%0b", locked);
        checks++;
        if (early !== 1'b0) begin
            errors++;
            $display("FAIL lock_early got locked=1 within 15 commas want 0");
        end
        send_idle();
        $display("lock: after 16 commas locked=%0b", locked);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_16 got %0b want 1", locked);
        end
    endtask

    task automatic test_back_to_back();
        send(16'h8005, 1'b0);
        $display("b2b: word 8005 trig=%0b num=%h seq=%0b", trig, trig_num, seq_err);
        checks++;
        if (trig !== 1'b1 || trig_num !== 15'h0005 || seq_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first got trig=%0b num=%h seq=%0b want 1 0005 0", trig, trig_num, seq_err);
        end
        send(16'h8006, 1'b0);
        $display("b2b: word 8006 trig=%0b num=%h seq=%0b tc=%0d", trig, trig_num, seq_err, trig_cnt);
        checks++;
        if (trig !== 1'b1 || trig_num !== 15'h0006 || seq_err !== 1'b0 || trig_cnt !== 32'd2) begin
            errors++;
            $display("FAIL b2b_second got trig=%0b num=%h seq=%0b tc=%0d want 1 0006 0 2",
                     trig, trig_num, seq_err, trig_cnt);
        end
        send_idle();
        $display("b2b: idle trig=%0b num=%h", trig, trig_num);
        checks++;
        if (trig !== 1'b0 || trig_num !== 15'h0006) begin
            errors++;
            $display("FAIL b2b_hold got trig=%0b num=%h want 0 0006", trig, trig_num);
        end
    endtask

    task automatic test_wrap();
        relock();
        send(16'hFFFF, 1'b0);
        $display("wrap: num 7fff trig=%0b num=%h seq=%0b", trig, trig_num, seq_err);
        checks++;
        if (trig !== 1'b1 || trig_num !== 15'h7FFF || seq_err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_7fff got trig=%0b num=%h seq=%0b want 1 7fff 0", trig, trig_num, seq_err);
        end
        send_idle();
        send(16'h8000, 1'b0);
        $display("wrap: num 0000 trig=%0b num=%h seq=%0b", trig, trig_num, seq_err);
        checks++;
        if (trig !== 1'b1 || trig_num !== 15'h0000 || seq_err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_0000 got trig=%0b num=%h seq=%0b want 1 0000 0", trig, trig_num, seq_err);
        end
        send(16'h8002, 1'b0);
        $display("wrap: num 0002 trig=%0b seq=%0b sc=%0d tc=%0d", trig, seq_err, seq_cnt, trig_cnt);
        checks++;
        if (trig !== 1'b1 || seq_err !== 1'b1 || seq_cnt !== 16'd1 || trig_cnt !== 32'd3) begin
            errors++;
            $display("FAIL wrap_gap got trig=%0b seq=%0b sc=%0d tc=%0d want 1 1 1 3",
                     trig, seq_err, seq_cnt, trig_cnt);
        end
        send_idle();
        checks++;
        if (seq_err !== 1'b0) begin
            errors++;
            $display("FAIL seq_strobe_len got %0b want 0", seq_err);
        end
    endtask

    task automatic test_bad_unlock();
        for (int i = 0; i < 3; i++) send(16'h1234, 1'b0);
        send_idle();
        $display("bad: 3 bad + idle bc=%0d locked=%0b", bad_cnt, locked);
        checks++;
        if (bad_cnt !== 16'd3 || locked !== 1'b1) begin
            errors++;
            $display("FAIL bad_three got bc=%0d locked=%0b want 3 1", bad_cnt, locked);
        end
        for (int i = 0; i < 3; i++) send(16'h1234, 1'b0);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL bad_hold3 got locked=%0b want 1", locked);
        end
        send(16'h00BD, 1'b1);
        $display("bad: 4th bad bc=%0d locked=%0b", bad_cnt, locked);
        checks++;
        if (bad_cnt !== 16'd7 || locked !== 1'b0) begin
            errors++;
            $display("FAIL bad_unlock got bc=%0d locked=%0b want 7 0", bad_cnt, locked);
        end
        send(16'h8020, 1'b0);
        $display("bad: trig in hunt trig=%0b tc=%0d", trig, trig_cnt);
        checks++;
        if (trig !== 1'b0 || trig_cnt !== 32'd3) begin
            errors++;
            $display("FAIL hunt_trig got trig=%0b tc=%0d want 0 3", trig, trig_cnt);
        end
    endtask

    task automatic test_hunt_restart();
        logic early;
        logic any_trig;
        early = 1'b0;
        for (int i = 0; i < 10; i++) send_idle();
        send(16'h8010, 1'b0);
        any_trig = trig;
        for (int i = 0; i < 15; i++) begin
            send_idle();
            early |= locked;
        end
        $display("hunt: trig in run trig=%0b locked after 15=%0b", any_trig, locked);
        checks++;
        if (any_trig !== 1'b0 || early !== 1'b0) begin
            errors++;
            $display("FAIL hunt_restart got trig=%0b early_lock=%0b want 0 0", any_trig, early);
        end
        send_idle();
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL hunt_relock got %0b want 1", locked);
        end
        send(16'h8100, 1'b0);
        $display("hunt: first trig 0100 trig=%0b seq=%0b sc=%0d", trig, seq_err, seq_cnt);
        checks++;
        if (trig !== 1'b1 || trig_num !== 15'h0100 || seq_err !== 1'b0 || seq_cnt !== 16'd1) begin
            errors++;
            $display("FAIL relock_first got trig=%0b num=%h seq=%0b sc=%0d want 1 0100 0 1",
                     trig, trig_num, seq_err, seq_cnt);
        end
    endtask

    task automatic test_saturate_clear();
        relock();
        send(16'h8001, 1'b0);
        send(16'h8003, 1'b0);
        checks++;
        if (s_trig_cnt !== 32'd2 || s_seq_cnt !== 16'd1 || s_locked !== 1'b1) begin
            errors++;
            $display("FAIL sat_pre got tc=%0d sc=%0d lock=%0b want 2 1 1", s_trig_cnt, s_seq_cnt, s_locked);
        end
        for (int i = 0; i < 65540; i++) send(16'h1234, 1'b0);
        $display("sat: 65540 bad bc=%h locked=%0b main bc=%0d", s_bad_cnt, s_locked, bad_cnt);
        checks++;
        if (s_bad_cnt !== 16'hFFFF || s_locked !== 1'b1) begin
            errors++;
            $display("FAIL sat_bad got bc=%h lock=%0b want ffff 1", s_bad_cnt, s_locked);
        end
        checks++;
        if (bad_cnt !== 16'd4 || locked !== 1'b0) begin
            errors++;
            $display("FAIL main_bad_hunt got bc=%0d lock=%0b want 4 0", bad_cnt, locked);
        end
        cnt_clr = 1'b1;
        send(16'h1234, 1'b0);
        cnt_clr = 1'b0;
        $display("clr: bc=%0d tc=%0d sc=%0d locked=%0b", s_bad_cnt, s_trig_cnt, s_seq_cnt, s_locked);
        checks++;
        if (s_bad_cnt !== 16'd0 || s_trig_cnt !== 32'd0 || s_seq_cnt !== 16'd0 || s_locked !== 1'b1) begin
            errors++;
            $display("FAIL clr_sat got bc=%0d tc=%0d sc=%0d lock=%0b want 0 0 0 1",
                     s_bad_cnt, s_trig_cnt, s_seq_cnt, s_locked);
        end
        checks++;
        if (bad_cnt !== 16'd0 || trig_cnt !== 32'd0 || seq_cnt !== 16'd0) begin
            errors++;
            $display("FAIL clr_main got bc=%0d tc=%0d sc=%0d want 0 0 0", bad_cnt, trig_cnt, seq_cnt);
        end
        send(16'h1234, 1'b0);
        $display("clr: next bad bc=%0d", s_bad_cnt);
        checks++;
        if (s_bad_cnt !== 16'd1) begin
            errors++;
            $display("FAIL clr_resume got bc=%0d want 1", s_bad_cnt);
        end
    endtask

    initial begin
        rst     = 1'b1;
        data    = 16'h0000;
        kchar   = 1'b0;
        cnt_clr = 1'b0;
        test_reset();
        test_lock();
        test_back_to_back();
        test_wrap();
        test_bad_unlock();
        test_hunt_restart();
        test_saturate_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
